bram_fifo: RTL and testbench
============================

# bram_fifo

Parametrised synchronous FIFO built on the dual-port block RAM: one write port, one registered read port, one clock. It generalises the fixed 32×8 dual-port RAM into a FIFO with configurable width and depth. It adds occupancy count, almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It sits between producer and consumer logic in the same clock domain and maps onto a single BRAM primitive.

## Interface
- DATA_WIDTH, 8: width of Write_data / Read_data.
- ADDR_WIDTH, 5: RAM address width; DEPTH = 2**ADDR_WIDTH entries.
- ALMOST_FULL_LVL, 30: Almost_full asserted when Count >= this value.
- ALMOST_EMPTY_LVL, 2: Almost_empty asserted when Count <= this value.

- Clk  in  1  clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Clr  in  1  synchronous flush; highest priority after reset.
- WR_en  in  1  write request.
- Write_data  in  DATA_WIDTH  data to push.
- RD_en  in  1  read request.
- Read_data  out  DATA_WIDTH  registered read data.
- Read_valid  out  1  Read_data holds a newly popped word this cycle.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.
- Almost_full  out  1  Count >= ALMOST_FULL_LVL.
- Almost_empty  out  1  Count <= ALMOST_EMPTY_LVL.
- Count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- Overflow  out  1  sticky: a write was rejected.
- Underflow  out  1  sticky: a read was rejected.

## Operation
- Storage: DEPTH×DATA_WIDTH RAM with synchronous write and synchronous (registered) read. Contents are not reset or cleared.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0. Count is held in its own register.
- Accepted write: WR_en && !Full. Write_data is stored at wr_ptr, and wr_ptr increments.
- Accepted read: RD_en && !Empty. RAM[rd_ptr] is loaded into Read_data, and rd_ptr increments.
- Acceptance uses the Full/Empty values present before the edge. A read and a write in the same cycle do not qualify each other:
  - When full, WR_en is rejected even if RD_en is also accepted.
  - When empty, RD_en is rejected even if WR_en is also accepted.
- Count update:
  - Increments on write-only.
  - Decrements on read-only.
  - Unchanged when both are accepted or neither is.
- Rejected write (WR_en && Full) sets Overflow. Rejected read (RD_en && Empty) sets Underflow. Both flags stay set until Clr or reset.
- Clr=1 at an edge:
  - Pointers, Count, Read_valid, Overflow and Underflow all go to 0.
  - WR_en and RD_en are ignored that cycle.
  - Read_data holds its value.
- Full, Empty, Almost_full and Almost_empty are decoded only from the registered Count. There is no combinational path from inputs to any output.

## Timing
- Reset (Reset_n=0, asynchronous, immediate):
  - Pointers, Count, Read_data, Read_valid, Overflow, Underflow and Full go to 0.
  - Empty=1.
  - Almost_empty=1.
  - Almost_full=0, unless ALMOST_FULL_LVL==0.
- Deassertion: the first accepted operation occurs at the first rising edge with Reset_n=1.
- Write-to-status latency: 1 cycle. Count, Full and Almost_* reflect a write right after the accepting edge.
- Read latency: 1 cycle. After an accepted read at edge N, Read_data holds the word and Read_valid=1 until edge N+1.
  - Read_valid is high for exactly one cycle per accepted read, and is back-to-back for consecutive reads.
  - Read_data holds its last value when Read_valid=0.
- Write-to-read latency: a word written at edge N can be popped by a read accepted at edge N+1 (Empty falls after edge N). It appears on Read_data after edge N+1.
- Full throughput: one write plus one read per cycle, indefinitely, when 0 < Count < DEPTH.
- Wrap-around: pointer rollover is invisible; data order is preserved across the DEPTH-1 → 0 boundary.
- Reset mid-operation: in-flight Read_valid is dropped immediately, and stored data is treated as lost.

## Test plan
- Reset: assert Reset_n=0 asynchronously between edges. Outputs must go to their reset values at once: Empty=1, Count=0, Read_valid=0, Overflow=Underflow=0.
- Fill and overflow:
  - Write 1..32 on consecutive cycles. Count must step 1..32; Almost_full rises after the 30th write; Full rises after the 32nd.
  - A 33rd write (value 33) must leave Count=32 and set Overflow=1.
- Drain and order:
  - Assert RD_en for 32 cycles. Read_data must be 1..32 in order, each with Read_valid=1 one cycle after its read.
  - Empty must rise after the last read; Almost_empty rises once Count ≤2.
  - A further RD_en must set Underflow, keep Read_valid=0 and hold Read_data=32.
- Simultaneous operations and wrap:
  - Preload 5 words, then assert WR_en+RD_en for 40 cycles with an incrementing pattern. Count must stay 5, and the output sequence must match the input sequence delayed by 5 words across the pointer wrap.
  - At Full, WR_en+RD_en: the read completes, the write is rejected, Count=31, Overflow=1.
- Clr mid-operation: at Count=10 with Overflow=1, pulse Clr together with WR_en. Expected: Count=0, Empty=1, Overflow=0, and no write taken. The next write/read must return that written value.
- Empty-edge simultaneity: at Count=0, WR_en+RD_en with data 0xA5. The read is rejected (Underflow=1), Count=1, and the next read returns 0xA5.

Source files
------------

// File: rtl/bram_fifo.sv
// Synchronous single-clock FIFO on a dual-port block RAM (one write port, one registered read port)
// with occupancy count, almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module bram_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 5,
  parameter int ALMOST_FULL_LVL  = 30,
  parameter int ALMOST_EMPTY_LVL = 2
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Clr,
  input  logic                  WR_en,
  input  logic [DATA_WIDTH-1:0] Write_data,
  input  logic                  RD_en,
  output logic [DATA_WIDTH-1:0] Read_data,
  output logic                  Read_valid,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_full,
  output logic                  Almost_empty,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] readData_q;
  logic                  readValid_q, readValid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wrAccept, rdAccept;

  // Status flags come only from the registered count, so no input reaches an output combinationally.
  assign Full         = (int'(count_q) == DEPTH);
  assign Empty        = (count_q == '0);
  assign Almost_full  = (int'(count_q) >= ALMOST_FULL_LVL);
  assign Almost_empty = (int'(count_q) <= ALMOST_EMPTY_LVL);

  // Acceptance uses pre-edge Full/Empty, so a simultaneous read never makes room for a write.
  assign wrAccept = WR_en && !Full && !Clr;
  assign rdAccept = RD_en && !Empty && !Clr;

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    readValid_d = rdAccept;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (Clr) begin
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wrAccept) wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
      if (rdAccept) rdPtr_d = rdPtr_q + ADDR_WIDTH'(1);
      if (wrAccept && !rdAccept) count_d = count_q + (ADDR_WIDTH + 1)'(1);
      if (rdAccept && !wrAccept) count_d = count_q - (ADDR_WIDTH + 1)'(1);
      if (WR_en && Full)  overflow_d  = 1'b1;
      if (RD_en && Empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      readValid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      readValid_q <= readValid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // RAM array has no reset so it maps onto a block RAM primitive.
  always_ff @(posedge Clk) begin
    if (wrAccept) mem[wrPtr_q] <= Write_data;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      readData_q <= '0;
    end else if (rdAccept) begin
      readData_q <= mem[rdPtr_q];
    end
  end

  assign Read_data  = readData_q;
  assign Read_valid = readValid_q;
  assign Count      = count_q;
  assign Overflow   = overflow_q;
  assign Underflow  = underflow_q;

endmodule

// File: tb/tb_bram_fifo.sv
// Directed self-checking bench for bram_fifo with default parameters (8-bit data, 32 entries).
module tb_bram_fifo;

  logic       Clk;
  logic       Reset_n;
  logic       Clr;
  logic       WR_en;
  logic [7:0] Write_data;
  logic       RD_en;
  logic [7:0] Read_data;
  logic       Read_valid;
  logic       Full;
  logic       Empty;
  logic       Almost_full;
  logic       Almost_empty;
  logic [5:0] Count;
  logic       Overflow;
  logic       Underflow;

  int testsRun = 0;
  int testsFailed = 0;

  bram_fifo #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(5),
    .ALMOST_FULL_LVL(30),
    .ALMOST_EMPTY_LVL(2)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .Clr(Clr),
    .WR_en(WR_en),
    .Write_data(Write_data),
    .RD_en(RD_en),
    .Read_data(Read_data),
    .Read_valid(Read_valid),
    .Full(Full),
    .Empty(Empty),
    .Almost_full(Almost_full),
    .Almost_empty(Almost_empty),
    .Count(Count),
    .Overflow(Overflow),
    .Underflow(Underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hard time limit so the run always ends on its own.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, let the rising edge take them, then settle 1 time unit past it.
  task automatic applyStimulus(input logic wr, input logic [7:0] wdata, input logic rd, input logic clr);
    WR_en      = wr;
    Write_data = wdata;
    RD_en      = rd;
    Clr        = clr;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    Reset_n    = 1'b1;
    Clr        = 1'b0;
    WR_en      = 1'b0;
    RD_en      = 1'b0;
    Write_data = 8'h00;

    // Asynchronous reset asserted between clock edges must act at once.
    #7;
    Reset_n = 1'b0;
    #1;
    checkOutput("rst_empty", 32'(Empty), 32'd1);
    checkOutput("rst_count", 32'(Count), 32'd0);
    checkOutput("rst_valid", 32'(Read_valid), 32'd0);
    checkOutput("rst_ovf", 32'(Overflow), 32'd0);
    checkOutput("rst_udf", 32'(Underflow), 32'd0);
    checkOutput("rst_full", 32'(Full), 32'd0);
    checkOutput("rst_aempty", 32'(Almost_empty), 32'd1);
    checkOutput("rst_afull", 32'(Almost_full), 32'd0);
    checkOutput("rst_rdata", 32'(Read_data), 32'd0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // Fill with 1..32.
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      checkOutput("fill_count", 32'(Count), 32'(i));
      checkOutput("fill_afull", 32'(Almost_full), 32'(i >= 30));
      checkOutput("fill_full", 32'(Full), 32'(i == 32));
    end
    applyStimulus(1'b1, 8'd33, 1'b0, 1'b0);
    checkOutput("ovf_count", 32'(Count), 32'd32);
    checkOutput("ovf_flag", 32'(Overflow), 32'd1);
    checkOutput("ovf_full", 32'(Full), 32'd1);

    // Drain in order.
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_valid", 32'(Read_valid), 32'd1);
      checkOutput("drain_data", 32'(Read_data), 32'(i));
      checkOutput("drain_count", 32'(Count), 32'(32 - i));
      checkOutput("drain_aempty", 32'(Almost_empty), 32'((32 - i) <= 2));
      checkOutput("drain_empty", 32'(Empty), 32'(i == 32));
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("udf_flag", 32'(Underflow), 32'd1);
    checkOutput("udf_valid", 32'(Read_valid), 32'd0);
    checkOutput("udf_hold", 32'(Read_data), 32'd32);
    checkOutput("ovf_sticky", 32'(Overflow), 32'd1);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("clr_ovf", 32'(Overflow), 32'd0);
    checkOutput("clr_udf", 32'(Underflow), 32'd0);
    checkOutput("clr_hold", 32'(Read_data), 32'd32);

    // Preload 100..104, then 40 cycles of simultaneous push/pop across the pointer wrap.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(100 + i), 1'b0, 1'b0);
    checkOutput("pre_count", 32'(Count), 32'd5);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, 8'(105 + k), 1'b1, 1'b0);
      checkOutput("sim_count", 32'(Count), 32'd5);
      checkOutput("sim_valid", 32'(Read_valid), 32'd1);
      checkOutput("sim_data", 32'(Read_data), 32'(100 + k));
    end

    // FIFO now holds 140..144; top up to full with 145..171.
    for (int i = 0; i < 27; i++) applyStimulus(1'b1, 8'(145 + i), 1'b0, 1'b0);
    checkOutput("top_full", 32'(Full), 32'd1);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    checkOutput("fullrw_data", 32'(Read_data), 32'd140);
    checkOutput("fullrw_valid", 32'(Read_valid), 32'd1);
    checkOutput("fullrw_count", 32'(Count), 32'd31);
    checkOutput("fullrw_ovf", 32'(Overflow), 32'd1);
    checkOutput("fullrw_udf", 32'(Underflow), 32'd0);

    // Pop 141..161 to reach Count=10, then flush together with a write.
    for (int i = 0; i < 21; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("pre_clr_count", 32'(Count), 32'd10);
    checkOutput("pre_clr_data", 32'(Read_data), 32'd161);
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1);
    checkOutput("clrw_count", 32'(Count), 32'd0);
    checkOutput("clrw_empty", 32'(Empty), 32'd1);
    checkOutput("clrw_ovf", 32'(Overflow), 32'd0);
    checkOutput("clrw_valid", 32'(Read_valid), 32'd0);
    checkOutput("clrw_hold", 32'(Read_data), 32'd161);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    checkOutput("postclr_count", 32'(Count), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("postclr_data", 32'(Read_data), 32'h5A);
    checkOutput("postclr_valid", 32'(Read_valid), 32'd1);

    // Push and pop together while empty: only the push is taken.
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
    checkOutput("erw_udf", 32'(Underflow), 32'd1);
    checkOutput("erw_count", 32'(Count), 32'd1);
    checkOutput("erw_valid", 32'(Read_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("erw_data", 32'(Read_data), 32'hA5);
    checkOutput("erw_valid2", 32'(Read_valid), 32'd1);
    checkOutput("erw_count2", 32'(Count), 32'd0);

    // Reset while a popped word is being presented drops it immediately.
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("mid_valid_pre", 32'(Read_valid), 32'd1);
    WR_en = 1'b0;
    RD_en = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("mid_valid", 32'(Read_valid), 32'd0);
    checkOutput("mid_rdata", 32'(Read_data), 32'd0);
    checkOutput("mid_udf", 32'(Underflow), 32'd0);
    checkOutput("mid_empty", 32'(Empty), 32'd1);
    #3;
    Reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
